// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: single-cycle ALU results win, memory results queue and drain when idle.
// Optional macro WB_RETIRE_CNT_EN enables the committed-write counter on retire_cnt.
module writeback_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd_addr,
    input  logic [XLEN-1:0] alu_result,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd_addr,
    input  logic [XLEN-1:0] mem_data,
    output logic            wr_en,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic [31:0]     busy_mask,
    output logic [31:0]     retire_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [4:0]            addr_r [FIFO_DEPTH];
    logic [XLEN-1:0]       data_r [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] kill_r;
    logic [AW:0]           wr_ptr_r;
    logic [AW:0]           rd_ptr_r;

    logic                  empty_s;
    logic                  full_s;
    logic                  alu_issue_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  mem_issue_s;
    logic [AW-1:0]         wr_idx_s;
    logic [AW-1:0]         rd_idx_s;
    logic [AW-1:0]         scan_idx_s;
    logic [AW:0]           wr_ptr_n_s;
    logic [AW:0]           rd_ptr_n_s;
    logic [AW:0]           count_n_s;
    logic [4:0]            addr_n_s [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] kill_n_s;
    logic [31:0]           busy_n_s;

    assign mem_ready = !full_s;

    // Port arbitration, WAW kill, pointer update and next-state busy mask
    always_comb begin
        empty_s     = (wr_ptr_r == rd_ptr_r);
        full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        wr_idx_s    = wr_ptr_r[AW-1:0];
        rd_idx_s    = rd_ptr_r[AW-1:0];
        alu_issue_s = alu_valid && (alu_rd_addr != 5'd0);
        push_s      = mem_valid && !full_s && (mem_rd_addr != 5'd0);
        pop_s       = !alu_issue_s && !empty_s;
        mem_issue_s = pop_s && !kill_r[rd_idx_s];
        wr_ptr_n_s  = wr_ptr_r + {{AW{1'b0}}, push_s};
        rd_ptr_n_s  = rd_ptr_r + {{AW{1'b0}}, pop_s};
        count_n_s   = wr_ptr_n_s - rd_ptr_n_s;
        scan_idx_s  = {AW{1'b0}};
        busy_n_s    = 32'h0;
        // An ALU write is younger than everything already queued, so matching entries die;
        // the entry pushed this same cycle is younger still and starts un-killed.
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            addr_n_s[i] = addr_r[i];
            kill_n_s[i] = kill_r[i] | (alu_issue_s && (addr_r[i] == alu_rd_addr));
        end
        if (push_s) begin
            addr_n_s[wr_idx_s] = mem_rd_addr;
            kill_n_s[wr_idx_s] = 1'b0;
        end else begin
            addr_n_s[wr_idx_s] = addr_r[wr_idx_s];
        end
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            scan_idx_s = rd_ptr_n_s[AW-1:0] + AW'(k);
            if (((AW+1)'(k) < count_n_s) && !kill_n_s[scan_idx_s]) begin
                busy_n_s[addr_n_s[scan_idx_s]] = 1'b1;
            end else begin
                busy_n_s = busy_n_s;
            end
        end
        busy_n_s[0] = 1'b0;
    end

    // Queue storage, pointers and registered busy view
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r  <= {(AW+1){1'b0}};
            rd_ptr_r  <= {(AW+1){1'b0}};
            kill_r    <= {FIFO_DEPTH{1'b0}};
            busy_mask <= 32'h0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_r[i] <= 5'd0;
                data_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            wr_ptr_r  <= wr_ptr_n_s;
            rd_ptr_r  <= rd_ptr_n_s;
            kill_r    <= kill_n_s;
            busy_mask <= busy_n_s;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_r[i] <= addr_n_s[i];
            end
            if (push_s) begin
                data_r[wr_idx_s] <= mem_data;
            end
        end
    end

    // Registered write port; address/data hold their last value when idle
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_en   <= 1'b0;
            rd_addr <= 5'd0;
            rd_data <= {XLEN{1'b0}};
        end else if (alu_issue_s) begin
            wr_en   <= 1'b1;
            rd_addr <= alu_rd_addr;
            rd_data <= alu_result;
        end else if (mem_issue_s) begin
            wr_en   <= 1'b1;
            rd_addr <= addr_r[rd_idx_s];
            rd_data <= data_r[rd_idx_s];
        end else begin
            wr_en   <= 1'b0;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_r;

    // Count every edge that raises wr_en; wraps naturally
    always_ff @(posedge clk) begin
        if (!rst) begin
            retire_cnt_r <= 32'h0;
        end else if (alu_issue_s || mem_issue_s) begin
            retire_cnt_r <= retire_cnt_r + 32'd1;
        end
    end

    assign retire_cnt = retire_cnt_r;
`else
    assign retire_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: expected file writes are queued as stimulus is driven
// and popped whenever the DUT raises wr_en.
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd_addr;
    logic [31:0] alu_result;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd_addr;
    logic [31:0] mem_data;
    logic        wr_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] busy_mask;
    logic [31:0] retire_cnt;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  exp_retire = 0;

    writeback_arbiter #(.FIFO_DEPTH(2), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd_addr(alu_rd_addr), .alu_result(alu_result),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd_addr(mem_rd_addr), .mem_data(mem_data),
        .wr_en(wr_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy_mask(busy_mask), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md);
        alu_valid = av; alu_rd_addr = aa; alu_result = ad;
        mem_valid = mv; mem_rd_addr = ma; mem_data = md;
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic chk_retire(input string tag);
        @(negedge clk);
        #1;
`ifdef WB_RETIRE_CNT_EN
        check_eq(tag, retire_cnt, exp_retire);
`else
        check_eq(tag, retire_cnt, 32'h0);
`endif
    endtask

    // Scoreboard: every wr_en pulse must match the oldest expected write
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexp_wr", wr_en, 1'b0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_eq("wr_addr", rd_addr, e.addr);
                check_eq("wr_data", rd_data, e.data);
                exp_retire++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        alu_valid = 1'b0; alu_rd_addr = 5'd0; alu_result = 32'h0;
        mem_valid = 1'b0; mem_rd_addr = 5'd0; mem_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_wr_en", wr_en, 1'b0);
        check_eq("rst_rd_addr", rd_addr, 5'd0);
        check_eq("rst_rd_data", rd_data, 32'h0);
        check_eq("rst_busy", busy_mask, 32'h0);
        check_eq("rst_ready", mem_ready, 1'b1);
        check_eq("rst_retire", retire_cnt, 32'h0);
        rst = 1'b1;

        // ALU write, latency one
        expect_wr(5'd5, 32'h11);
        step(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0);
        check_eq("t1_wr_en", wr_en, 1'b1);
        idle();
        check_eq("t1_wr_off", wr_en, 1'b0);

        // Memory write, latency two, busy bit visible in between
        expect_wr(5'd7, 32'hAA);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hAA);
        check_eq("t2_busy", busy_mask, 32'h80);
        check_eq("t2_no_wr", wr_en, 1'b0);
        idle();
        check_eq("t2_wr_en", wr_en, 1'b1);
        check_eq("t2_busy_clr", busy_mask, 32'h0);

        // Queue fills while ALU owns the port, then drains in order
        expect_wr(5'd10, 32'hA0);
        step(1'b1, 5'd10, 32'hA0, 1'b1, 5'd3, 32'h33);
        check_eq("t3_ready0", mem_ready, 1'b1);
        expect_wr(5'd11, 32'hB0);
        step(1'b1, 5'd11, 32'hB0, 1'b1, 5'd4, 32'h44);
        check_eq("t3_full", mem_ready, 1'b0);
        check_eq("t3_busy", busy_mask, 32'h18);
        expect_wr(5'd12, 32'hC0);
        step(1'b1, 5'd12, 32'hC0, 1'b0, 5'd0, 32'h0);
        expect_wr(5'd13, 32'hD0);
        step(1'b1, 5'd13, 32'hD0, 1'b0, 5'd0, 32'h0);
        check_eq("t3_still_full", mem_ready, 1'b0);
        expect_wr(5'd3, 32'h33);
        expect_wr(5'd4, 32'h44);
        idle();
        check_eq("t3_ready_back", mem_ready, 1'b1);
        idle();
        check_eq("t3_busy_clr", busy_mask, 32'h0);

        // WAW kill: queued x9 superseded by the younger ALU write
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h1);
        check_eq("t4_busy_set", busy_mask, 32'h200);
        expect_wr(5'd9, 32'h2);
        step(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'h0);
        check_eq("t4_busy_kill", busy_mask, 32'h0);
        idle();
        check_eq("t4_killpop", wr_en, 1'b0);
        check_eq("t4_ready", mem_ready, 1'b1);

        // Same-cycle push to the ALU's register is younger and survives
        expect_wr(5'd6, 32'h60);
        expect_wr(5'd6, 32'h61);
        step(1'b1, 5'd6, 32'h60, 1'b1, 5'd6, 32'h61);
        check_eq("t4b_busy", busy_mask, 32'h40);
        idle();
        idle();

        // Push and pop together on a non-full queue
        expect_wr(5'd8, 32'h80);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h80);
        expect_wr(5'd14, 32'hE0);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'hE0);
        check_eq("pp_busy", busy_mask, 32'h4000);
        idle();
        idle();
        chk_retire("t5_retire_pre");

        // x0 destinations never reach the file nor the queue
        step(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
        check_eq("t5_busy", busy_mask, 32'h0);
        check_eq("t5_ready", mem_ready, 1'b1);
        idle();
        check_eq("t5_no_wr", wr_en, 1'b0);
        chk_retire("t5_retire_post");

        // Reset with a full queue discards it
        expect_wr(5'd1, 32'h101);
        step(1'b1, 5'd1, 32'h101, 1'b1, 5'd20, 32'h20);
        expect_wr(5'd2, 32'h102);
        step(1'b1, 5'd2, 32'h102, 1'b1, 5'd21, 32'h21);
        check_eq("t6_full", mem_ready, 1'b0);
        rst = 1'b0;
        idle();
        exp_retire = 0;
        check_eq("t6_wr_en", wr_en, 1'b0);
        check_eq("t6_ready", mem_ready, 1'b1);
        check_eq("t6_busy", busy_mask, 32'h0);
        check_eq("t6_retire", retire_cnt, 32'h0);
        rst = 1'b1;
        repeat (3) idle();
        chk_retire("t6_retire_after");

        check_eq("sb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
